// File: rtl/regfile_sb_pkg.sv
// -----------------------------------------------------------------------------
// regfile_sb_pkg
// Shared types and default sizing for the scoreboarded register file.
//   rf_state_e  : controller state (ST_INIT = initialisation sweep, ST_RUN)
//   DEF_DATA_W  : default register width in bits
//   DEF_ADDR_W  : default address width (DEPTH = 2**ADDR_W)
// -----------------------------------------------------------------------------
package regfile_sb_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } rf_state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

endpackage : regfile_sb_pkg

// File: rtl/regfile_sb_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_sb_scoreboard
// Pending-bit array for the register file. An issue marks a destination
// register as waiting for its producer; a writeback clears it. When both hit
// the same register in one cycle the issue wins, because it belongs to the
// newer producer. A writeback that finds its register not pending raises a
// sticky error flag that only reset clears.
//
// Ports:
//   clk        : clock, state updates on rising edge
//   rst        : asynchronous active-high reset (clears pending and error)
//   run        : high when the register file is in normal operation
//   iss_valid  : issue strobe
//   iss_addr   : register marked pending by the issue
//   wb_valid   : writeback strobe
//   wb_addr    : register cleared by the writeback
//   pending    : registered pending bit per register
//   err_wb     : registered sticky writeback-to-non-pending flag
// -----------------------------------------------------------------------------
module regfile_sb_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     wb_valid,
    input  logic [ADDR_W-1:0]        wb_addr,
    output logic [(2**ADDR_W)-1:0]   pending,
    output logic                     err_wb
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] pending_r;
    logic [DEPTH-1:0] pending_s;
    logic             err_r;
    logic             err_s;
    logic             iss_ok_s;
    logic             wb_ok_s;

    // Qualify strobes: ignored outside RUN, and register 0 is inert when hardwired
    always_comb begin
        iss_ok_s = 1'b0;
        wb_ok_s  = 1'b0;
        if (run) begin
            iss_ok_s = iss_valid && !((ZERO_REG != 0) && (iss_addr == '0));
            wb_ok_s  = wb_valid  && !((ZERO_REG != 0) && (wb_addr  == '0));
        end else begin
            iss_ok_s = 1'b0;
            wb_ok_s  = 1'b0;
        end
    end

    // Next pending vector: clear first, then set so a coinciding issue wins
    always_comb begin
        pending_s = pending_r;
        if (wb_ok_s) begin
            pending_s[wb_addr] = 1'b0;
        end else begin
            pending_s = pending_r;
        end
        if (iss_ok_s) begin
            pending_s[iss_addr] = 1'b1;
        end else begin
            pending_s[iss_addr] = pending_s[iss_addr];
        end
    end

    // Sticky error: judged against the pending state before this edge
    always_comb begin
        err_s = err_r;
        if (wb_ok_s && !pending_r[wb_addr]) begin
            err_s = 1'b1;
        end else begin
            err_s = err_r;
        end
    end

    // Pending and error registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r <= '0;
            err_r     <= 1'b0;
        end else begin
            pending_r <= pending_s;
            err_r     <= err_s;
        end
    end

    assign pending = pending_r;
    assign err_wb  = err_r;

endmodule : regfile_sb_scoreboard

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// Register file with a per-register pending scoreboard. After reset an
// initialisation sweep writes one register per cycle (address i gets i, or 0
// when INDEX_INIT=0); ready rises once the sweep has finished. During the
// sweep reads return 0, busy reads 0 and issue/writeback strobes are ignored.
// The storage array is not reset; the sweep rewrites every entry instead.
//
// Optional feature:
//   REGFILE_SB_BYPASS_EN : when defined, a read that matches a writeback in the
//                          same cycle returns wb_data combinationally and busy
//                          shows the pending value after the edge. Undefined:
//                          the read sees the stored value and current pending.
//
// Ports:
//   clk                : clock, rising-edge
//   rst                : asynchronous active-high reset, restarts the sweep
//   ready              : registered, high once the sweep is complete
//   rd_addr1/rd_addr2  : read addresses
//   rd_data1/rd_data2  : combinational read data
//   rd_busy1/rd_busy2  : pending bit of the addressed register
//   iss_valid/iss_addr : mark destination register pending
//   wb_valid/wb_addr/wb_data : write data and clear pending
//   err_wb             : sticky flag, writeback to a non-pending register
// -----------------------------------------------------------------------------
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int INDEX_INIT = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              err_wb
);

    localparam int DEPTH = 2**ADDR_W;

    rf_state_e         state_r;
    rf_state_e         state_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] cnt_s;
    logic              ready_r;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic [DATA_W-1:0] init_val_s;
    logic              wb_drop_s;
    logic              run_s;

    logic [DEPTH-1:0]  pending_s;
    logic [ADDR_W-1:0] raddr_s [2];
    logic [DATA_W-1:0] rdata_s [2];
    logic              rbusy_s [2];

    assign run_s = (state_r == ST_RUN);

    // Sweep value; the size cast zero-extends or truncates the index to DATA_W
    always_comb begin
        init_val_s = '0;
        if (INDEX_INIT != 0) begin
            init_val_s = DATA_W'(cnt_r);
        end else begin
            init_val_s = '0;
        end
    end

    // Next-state logic: advance the sweep, enter RUN after the last address
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_INIT: begin
                if (cnt_r == ADDR_W'(DEPTH - 1)) begin
                    state_s = ST_RUN;
                    cnt_s   = '0;
                end else begin
                    state_s = ST_INIT;
                    cnt_s   = cnt_r + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                state_s = ST_RUN;
                cnt_s   = '0;
            end
            default: begin
                state_s = ST_INIT;
                cnt_s   = '0;
            end
        endcase
    end

    // State, sweep counter and ready registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_INIT;
            cnt_r   <= '0;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            ready_r <= (state_s == ST_RUN);
        end
    end

    assign ready = ready_r;

    // Hardwired register 0 swallows writebacks
    assign wb_drop_s = (ZERO_REG != 0) && (wb_addr == '0);

    // Single write port shared by the sweep and the writeback path
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = '0;
        mem_wdata_s = '0;
        if (state_r == ST_INIT) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = cnt_r;
            mem_wdata_s = init_val_s;
        end else if (wb_valid && !wb_drop_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = wb_addr;
            mem_wdata_s = wb_data;
        end else begin
            mem_we_s    = 1'b0;
        end
    end

    // Storage array, intentionally without reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    regfile_sb_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .run       (run_s),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .pending   (pending_s),
        .err_wb    (err_wb)
    );

    assign raddr_s[0] = rd_addr1;
    assign raddr_s[1] = rd_addr2;

    // Read ports: INIT and register 0 read as zero ahead of any bypass
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata_s[p] = '0;
            rbusy_s[p] = 1'b0;
            if (!run_s) begin
                rdata_s[p] = '0;
                rbusy_s[p] = 1'b0;
            end else if ((ZERO_REG != 0) && (raddr_s[p] == '0)) begin
                rdata_s[p] = '0;
                rbusy_s[p] = 1'b0;
`ifdef REGFILE_SB_BYPASS_EN
            end else if (wb_valid && (wb_addr == raddr_s[p])) begin
                // Post-edge view: the writeback clears, a coinciding issue re-sets
                rdata_s[p] = wb_data;
                rbusy_s[p] = iss_valid && (iss_addr == raddr_s[p]);
`endif
            end else begin
                rdata_s[p] = mem_r[raddr_s[p]];
                rbusy_s[p] = pending_s[raddr_s[p]];
            end
        end
    end

    assign rd_data1 = rdata_s[0];
    assign rd_data2 = rdata_s[1];
    assign rd_busy1 = rbusy_s[0];
    assign rd_busy2 = rbusy_s[1];

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb
// Self-checking bench for regfile_sb with default parameters. A behavioural
// model (arrays plus a sweep count) predicts every output on each falling
// edge; directed steps with literal expectations pin the model, then a
// randomized phase exercises issue/writeback/reset interleavings.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          ready;
    logic [AW-1:0] rd_addr1  = '0;
    logic [AW-1:0] rd_addr2  = '0;
    logic [DW-1:0] rd_data1;
    logic [DW-1:0] rd_data2;
    logic          rd_busy1;
    logic          rd_busy2;
    logic          iss_valid = 1'b0;
    logic [AW-1:0] iss_addr  = '0;
    logic          wb_valid  = 1'b0;
    logic [AW-1:0] wb_addr   = '0;
    logic [DW-1:0] wb_data   = '0;
    logic          err_wb;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    logic [DW-1:0]    mem_m [DEPTH];
    logic [DEPTH-1:0] pend_m  = '0;
    logic             err_m   = 1'b0;
    int               sweep_m = 0;

    regfile_sb dut (
        .clk       (clk),
        .rst       (rst),
        .ready     (ready),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .rd_busy1  (rd_busy1),
        .rd_busy2  (rd_busy2),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .err_wb    (err_wb)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model update: sweep for DEPTH edges, then apply writeback and issue rules
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sweep_m <= 0;
            pend_m  <= '0;
            err_m   <= 1'b0;
        end else if (sweep_m < DEPTH) begin
            mem_m[sweep_m] <= 32'(sweep_m);
            sweep_m        <= sweep_m + 1;
        end else begin
            if (wb_valid && wb_addr != 0) begin
                mem_m[wb_addr]  <= wb_data;
                pend_m[wb_addr] <= 1'b0;
                if (!pend_m[wb_addr]) err_m <= 1'b1;
            end
            if (iss_valid && iss_addr != 0) pend_m[iss_addr] <= 1'b1;
        end
    end

    function automatic logic [31:0] exp_data(input logic [AW-1:0] a);
        if (sweep_m < DEPTH) return 32'd0;
        if (a == 0) return 32'd0;
`ifdef REGFILE_SB_BYPASS_EN
        if (wb_valid && wb_addr == a) return wb_data;
`endif
        return mem_m[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (sweep_m < DEPTH) return 1'b0;
        if (a == 0) return 1'b0;
`ifdef REGFILE_SB_BYPASS_EN
        if (wb_valid && wb_addr == a) return iss_valid && (iss_addr == a);
`endif
        return pend_m[a];
    endfunction

    // Every-cycle comparison against the model, mid-cycle
    always @(negedge clk) begin
        check("ready",    {31'd0, ready},    {31'd0, sweep_m >= DEPTH});
        check("err_wb",   {31'd0, err_wb},   {31'd0, err_m});
        check("rd_data1", rd_data1,          exp_data(rd_addr1));
        check("rd_data2", rd_data2,          exp_data(rd_addr2));
        check("rd_busy1", {31'd0, rd_busy1}, {31'd0, exp_busy(rd_addr1)});
        check("rd_busy2", {31'd0, rd_busy2}, {31'd0, exp_busy(rd_addr2)});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid = 1'b0;
        wb_valid  = 1'b0;
    endtask

    // Release reset and confirm ready rises on exactly the 32nd edge
    task automatic release_and_sweep(input string tag);
        rst = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            step();
            if (k == DEPTH - 1) check({tag, "_ready_e31"}, {31'd0, ready}, 32'd0);
            if (k == DEPTH)     check({tag, "_ready_e32"}, {31'd0, ready}, 32'd1);
        end
    endtask

    initial begin
        logic [AW-1:0] pick;
        logic          found;
        int            start;

        // Reset release and sweep timing
        repeat (3) step();
        release_and_sweep("rst0");
        rd_addr1 = 5'd7;
        rd_addr2 = 5'd0;
        #1;
        check("init_r7", rd_data1, 32'd7);
        check("init_r0", rd_data2, 32'd0);

        // Issue then writeback of register 5
        iss_valid = 1'b1; iss_addr = 5'd5;
        step();
        idle();
        rd_addr1 = 5'd5;
        #1;
        check("iss5_busy", {31'd0, rd_busy1}, 32'd1);
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        step();
        idle();
        #1;
        check("wb5_data", rd_data1, 32'hDEADBEEF);
        check("wb5_busy", {31'd0, rd_busy1}, 32'd0);
        check("wb5_err",  {31'd0, err_wb}, 32'd0);

        // Same-cycle issue and writeback to register 9 (9 already pending)
        iss_valid = 1'b1; iss_addr = 5'd9;
        step();
        wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h00001234;
        step();
        idle();
        rd_addr1 = 5'd9;
        rd_addr2 = 5'd9;
        #1;
        check("same9_d1", rd_data1, 32'h00001234);
        check("same9_d2", rd_data2, 32'h00001234);
        check("same9_b1", {31'd0, rd_busy1}, 32'd1);
        check("same9_b2", {31'd0, rd_busy2}, 32'd1);
        check("same9_err", {31'd0, err_wb}, 32'd0);

        // Writeback to non-pending register 3, then to register 0
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h33330003;
        step();
        idle();
        rd_addr1 = 5'd3;
        #1;
        check("wb3_data", rd_data1, 32'h33330003);
        check("wb3_err",  {31'd0, err_wb}, 32'd1);
        repeat (5) step();
        check("wb3_err_hold", {31'd0, err_wb}, 32'd1);
        wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
        step();
        idle();
        rd_addr1 = 5'd0;
        #1;
        check("wb0_data", rd_data1, 32'd0);
        check("wb0_busy", {31'd0, rd_busy1}, 32'd0);

        // Read of register 4 coinciding with its writeback
        rd_addr1 = 5'd4;
        wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'hA5A5A5A5;
        #1;
`ifdef REGFILE_SB_BYPASS_EN
        check("byp4_same", rd_data1, 32'hA5A5A5A5);
`else
        check("byp4_same", rd_data1, 32'd4);
`endif
        step();
        idle();
        #1;
        check("byp4_next", rd_data1, 32'hA5A5A5A5);

        // Reset mid-RUN with pending bits set, then again at sweep count 10
        iss_valid = 1'b1; iss_addr = 5'd12;
        step();
        iss_addr = 5'd20;
        step();
        idle();
        rst = 1'b1;
        #1;
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_err",   {31'd0, err_wb}, 32'd0);
        step();
        rst = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        #1;
        check("rst10_ready", {31'd0, ready}, 32'd0);
        step();
        release_and_sweep("rst10");
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr1 = AW'(a);
            #1;
            check("post_rst_busy", {31'd0, rd_busy1}, 32'd0);
            check("post_rst_data", rd_data1, 32'(a));
        end
        check("post_rst_err", {31'd0, err_wb}, 32'd0);

        // Randomized traffic with occasional reset pulses
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 599) == 0);
            rd_addr1  = AW'($urandom_range(0, DEPTH - 1));
            rd_addr2  = ($urandom_range(0, 7) == 0) ? rd_addr1 : AW'($urandom_range(0, DEPTH - 1));
            iss_valid = ($urandom_range(0, 2) == 0);
            iss_addr  = AW'($urandom_range(0, DEPTH - 1));
            wb_valid  = ($urandom_range(0, 1) == 0);
            wb_data   = $urandom;
            pick      = AW'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 3) != 0) begin
                found = 1'b0;
                start = $urandom_range(0, DEPTH - 1);
                for (int j = 0; j < DEPTH; j++) begin
                    if (!found && pend_m[(start + j) % DEPTH]) begin
                        pick  = AW'((start + j) % DEPTH);
                        found = 1'b1;
                    end
                end
            end
            wb_addr = pick;
            if ($urandom_range(0, 5) == 0) rd_addr1 = wb_addr;
            if ($urandom_range(0, 9) == 0) iss_addr = wb_addr;
            step();
        end

        rst = 1'b0;
        idle();
        step();
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_regfile_sb

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning address width; DEPTH = 2**ADDR_W registers.
REQ-003 The block SHALL have parameter INDEX_INIT, default 1, meaning 1: register i initialised to i (zero-extended/truncated to DATA_W); 0: all registers initialised to 0.
REQ-004 The block SHALL have parameter ZERO_REG, default 1, meaning 1: register 0 reads 0, ignores writes and issues.
REQ-005 Port clk  input  1  single clock; all state updates on rising edge.
REQ-006 Port rst  input  1  reset, asynchronous, active-high.
REQ-007 Port ready  output  1  high when initialisation sweep complete.
REQ-008 Ports rd_addr1, rd_addr2  input  ADDR_W  read addresses.
REQ-009 Ports rd_data1, rd_data2  output  DATA_W  combinational read data.
REQ-010 Ports rd_busy1, rd_busy2  output  1  pending bit of addressed register.
REQ-011 Ports iss_valid (1), iss_addr (ADDR_W)  input  mark destination register pending.
REQ-012 Ports wb_valid (1), wb_addr (ADDR_W), wb_data (DATA_W)  input  write back and clear pending.
REQ-013 Port err_wb  output  1  sticky: writeback seen to a non-pending register.

Function
REQ-014 The block SHALL implement two states, INIT and RUN; INIT entered on reset, RUN entered the cycle after the last sweep write.
REQ-015 In INIT a counter SHALL write one register per cycle, addresses 0..DEPTH-1 ascending, with the INDEX_INIT value; ready SHALL rise exactly DEPTH rising edges after rst deasserts.
REQ-016 In INIT, rd_data SHALL read 0, rd_busy SHALL read 0, and iss_valid/wb_valid SHALL be ignored.
REQ-017 In RUN, wb_valid SHALL write wb_data to wb_addr on the rising edge; with ZERO_REG=1, writes to address 0 SHALL be dropped.
REQ-018 In RUN, iss_valid SHALL set pending[iss_addr]; wb_valid SHALL clear pending[wb_addr].
REQ-019 Simultaneous issue and writeback to the same address SHALL write the data and leave pending set (new producer wins).
REQ-020 Writeback to a non-pending register SHALL still write data and SHALL set err_wb, which holds until reset.
REQ-021 With ZERO_REG=1, rd_data for address 0 SHALL be 0 and rd_busy SHALL be 0 regardless of state.
REQ-022 Both read ports SHALL be independent; identical addresses SHALL return identical values.

Reset
REQ-023 Asserting rst SHALL immediately force: state INIT, sweep counter 0, ready 0, all pending bits 0, err_wb 0.
REQ-024 Reset asserted mid-sweep or mid-RUN SHALL restart the sweep from address 0; the storage array itself is not asynchronously cleared.

Configuration
REQ-025 With macro REGFILE_SB_BYPASS_EN defined, a read whose address equals wb_addr while wb_valid is high in RUN SHALL return wb_data combinationally and rd_busy SHALL report the post-edge pending value (0 unless a same-address issue coincides).
REQ-026 Without REGFILE_SB_BYPASS_EN, such a read SHALL return the old stored value and the current pending bit; new data visible the following cycle.
REQ-027 The ZERO_REG rule SHALL override bypass.

Structure
REQ-028 Package regfile_sb_pkg SHALL hold the INIT/RUN state enum and the default DATA_W/ADDR_W constants.
REQ-029 The pending-bit array, its set/clear priority and err_wb SHALL be a sub-module regfile_sb_scoreboard; storage and sweep remain in regfile_sb.

Verification
REQ-030 Reset release, defaults -> ready low 32 cycles, high on edge 32; rd_addr1=7 reads 7, rd_addr2=0 reads 0.
REQ-031 iss 5, next cycle rd_busy1(addr 5)=1; wb 5 data 0xDEADBEEF -> after edge rd_data1=0xDEADBEEF, rd_busy1=0, err_wb=0.
REQ-032 Same-cycle iss_valid and wb_valid to address 9, data 0x1234 -> rd_data=0x1234, rd_busy=1.
REQ-033 wb to non-pending address 3 -> written, err_wb=1 and stays 1 until rst; wb to address 0 -> reads 0.
REQ-034 rst pulsed at sweep count 10 -> ready low a further full 32 cycles after deassertion, all pending 0.
REQ-035 Bypass: wb_valid addr 4 data 0xA5A5A5A5 with rd_addr1=4 -> rd_data1=0xA5A5A5A5 same cycle if REGFILE_SB_BYPASS_EN defined, else old value then 0xA5A5A5A5 next cycle.
